wb_mem_seq: RTL and testbench

- Write-back memory sequencer. Sits directly upstream of the mem stage's write-back port (wb_memdata/wb_memaddr/wb_size/wb_valid/wb_ptcid, back-pressured by wbaq_isfull).
- Accepts one retiring instruction with up to four destinations. Serialises only the destinations flagged as memory into single-entry writes into the mem stage's write-back address queue.
- Stalls the write-back stage while writes remain pending.

---
 rtl/wb_mem_seq.sv | 128 ++++++++++++
 tb/tb_wb_mem_seq.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_mem_seq.sv
// Write-back memory sequencer: serialises the memory-bound destinations of one retiring
// instruction into single writes. Optional stall counter enabled by WB_MEM_SEQ_FULLCNT_EN.
module wb_mem_seq #(
    parameter int unsigned NUM_DEST  = 4,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 valid_in,
    input  logic [63:0]          res1,
    input  logic [63:0]          res2,
    input  logic [63:0]          res3,
    input  logic [63:0]          res4,
    input  logic [31:0]          dest1_addr,
    input  logic [31:0]          dest2_addr,
    input  logic [31:0]          dest3_addr,
    input  logic [31:0]          dest4_addr,
    input  logic                 dest1_is_mem,
    input  logic                 dest2_is_mem,
    input  logic                 dest3_is_mem,
    input  logic                 dest4_is_mem,
    input  logic [1:0]           opsize_in,
    input  logic [6:0]           inst_ptcid_in,
    input  logic                 wbaq_isfull,
    output logic [63:0]          wb_memdata,
    output logic [31:0]          wb_memaddr,
    output logic [1:0]           wb_size,
    output logic                 wb_valid,
    output logic [6:0]           wb_ptcid,
    output logic                 stall_out,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] full_cycles
);

    typedef enum logic [0:0] {StIdle, StIssue} state_e;

    state_e                        state_q, state_d;
    logic [NUM_DEST-1:0]           mask_q, mask_d;
    logic [NUM_DEST-1:0][63:0]     data_q, data_d;
    logic [NUM_DEST-1:0][31:0]     addr_q, addr_d;
    logic [1:0]                    size_q, size_d;
    logic [6:0]                    ptcid_q, ptcid_d;

    logic [1:0] sel_idx;
    logic       one_left;
    logic       last;
    logic       accept;

    // Slot 1 has highest priority: scan downwards so the lowest set bit wins.
    always_comb begin
        sel_idx = 2'd0;
        for (int i = NUM_DEST - 1; i >= 0; i--) begin
            if (mask_q[i]) sel_idx = 2'(i);
        end
    end

    assign one_left  = (mask_q != '0) &&
                       ((mask_q & (mask_q - {{(NUM_DEST-1){1'b0}}, 1'b1})) == '0);
    assign busy      = (state_q == StIssue);
    assign wb_valid  = busy & ~wbaq_isfull;
    assign last      = wb_valid & one_left;
    assign stall_out = busy & ~last;
    assign accept    = valid_in & ~stall_out;

    assign wb_memdata = busy ? data_q[sel_idx] : '0;
    assign wb_memaddr = busy ? addr_q[sel_idx] : '0;
    assign wb_size    = busy ? size_q : '0;
    assign wb_ptcid   = busy ? ptcid_q : '0;

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        data_d  = data_q;
        addr_d  = addr_q;
        size_d  = size_q;
        ptcid_d = ptcid_q;
        if (wb_valid) begin
            mask_d[sel_idx] = 1'b0;
            if (last) state_d = StIdle;
        end
        // A new instruction taken alongside the final write replaces the emptied mask.
        if (accept) begin
            data_d  = {res4, res3, res2, res1};
            addr_d  = {dest4_addr, dest3_addr, dest2_addr, dest1_addr};
            size_d  = opsize_in;
            ptcid_d = inst_ptcid_in;
            mask_d  = {dest4_is_mem, dest3_is_mem, dest2_is_mem, dest1_is_mem};
            state_d = (mask_d != '0) ? StIssue : StIdle;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= StIdle;
            mask_q  <= '0;
            data_q  <= '0;
            addr_q  <= '0;
            size_q  <= '0;
            ptcid_q <= '0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            ptcid_q <= ptcid_d;
        end
    end

`ifdef WB_MEM_SEQ_FULLCNT_EN
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (busy && wbaq_isfull && (cnt_q != '1)) cnt_d = cnt_q + CNT_WIDTH'(1);
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign full_cycles = cnt_q;
`else
    assign full_cycles = '0;
`endif

endmodule

// File: tb/tb_wb_mem_seq.sv
// Self-checking bench for wb_mem_seq: directed sequences, a vector table and random traffic
// checked against a queue-based model of pending writes.
module tb_wb_mem_seq;

    logic        clk = 1'b0;
    logic        clr;
    logic        valid_in;
    logic [63:0] res [4];
    logic [31:0] addr [4];
    logic [3:0]  is_mem;
    logic [1:0]  opsize_in;
    logic [6:0]  inst_ptcid_in;
    logic        wbaq_isfull;
    logic [63:0] wb_memdata;
    logic [31:0] wb_memaddr;
    logic [1:0]  wb_size;
    logic        wb_valid;
    logic [6:0]  wb_ptcid;
    logic        stall_out;
    logic        busy;
    logic [15:0] full_cycles;

    always #5 clk = ~clk;

    wb_mem_seq dut (
        .clk           (clk),
        .clr           (clr),
        .valid_in      (valid_in),
        .res1          (res[0]),
        .res2          (res[1]),
        .res3          (res[2]),
        .res4          (res[3]),
        .dest1_addr    (addr[0]),
        .dest2_addr    (addr[1]),
        .dest3_addr    (addr[2]),
        .dest4_addr    (addr[3]),
        .dest1_is_mem  (is_mem[0]),
        .dest2_is_mem  (is_mem[1]),
        .dest3_is_mem  (is_mem[2]),
        .dest4_is_mem  (is_mem[3]),
        .opsize_in     (opsize_in),
        .inst_ptcid_in (inst_ptcid_in),
        .wbaq_isfull   (wbaq_isfull),
        .wb_memdata    (wb_memdata),
        .wb_memaddr    (wb_memaddr),
        .wb_size       (wb_size),
        .wb_valid      (wb_valid),
        .wb_ptcid      (wb_ptcid),
        .stall_out     (stall_out),
        .busy          (busy),
        .full_cycles   (full_cycles)
    );

    typedef struct {
        logic [31:0] a;
        logic [63:0] d;
    } wr_t;

    typedef struct {
        logic [3:0]  mem;
        logic [31:0] first_addr;
        int          nwrites;
    } vec_t;

    wr_t         pend[$];
    logic [1:0]  m_size;
    logic [6:0]  m_pt;
    int unsigned m_cnt;
    int          checks;
    int          errors;
    logic        s_valid, s_stall, s_busy;
    logic [31:0] s_addr;
    logic        last_acc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs are already set (at the negedge); compare, then advance one clock.
    task automatic step();
        logic eb, ev, es;
        wr_t  h;
        #1;
        eb = (pend.size() > 0);
        ev = eb && !wbaq_isfull;
        es = eb && !(ev && pend.size() == 1);
        h  = eb ? pend[0] : '{a: 32'h0, d: 64'h0};
        chk("wb_valid", 64'(wb_valid), 64'(ev));
        chk("stall_out", 64'(stall_out), 64'(es));
        chk("busy", 64'(busy), 64'(eb));
        chk("wb_memaddr", 64'(wb_memaddr), 64'(h.a));
        chk("wb_memdata", wb_memdata, h.d);
        chk("wb_size", 64'(wb_size), eb ? 64'(m_size) : 64'h0);
        chk("wb_ptcid", 64'(wb_ptcid), eb ? 64'(m_pt) : 64'h0);
`ifdef WB_MEM_SEQ_FULLCNT_EN
        chk("full_cycles", 64'(full_cycles), 64'(m_cnt));
`else
        chk("full_cycles", 64'(full_cycles), 64'h0);
`endif
        s_valid  = wb_valid;
        s_stall  = stall_out;
        s_busy   = busy;
        s_addr   = wb_memaddr;
        last_acc = valid_in && !es;
        @(posedge clk);
        if (eb && wbaq_isfull && m_cnt < 32'hFFFF) m_cnt++;
        if (ev) void'(pend.pop_front());
        if (last_acc) begin
            pend.delete();
            for (int i = 0; i < 4; i++)
                if (is_mem[i]) pend.push_back('{a: addr[i], d: res[i]});
            m_size = opsize_in;
            m_pt   = inst_ptcid_in;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        clr = 1'b1;
        pend.delete();
        m_cnt = 0;
        #1;
        chk("rst_valid", 64'(wb_valid), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_stall", 64'(stall_out), 64'h0);
        chk("rst_addr", 64'(wb_memaddr), 64'h0);
        chk("rst_cnt", 64'(full_cycles), 64'h0);
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic set_instr(input logic [3:0] mem, input logic [31:0] a1, input logic [31:0] a2,
                             input logic [31:0] a3, input logic [31:0] a4);
        valid_in = 1'b1;
        is_mem   = mem;
        addr[0] = a1; addr[1] = a2; addr[2] = a3; addr[3] = a4;
        for (int i = 0; i < 4; i++) res[i] = {$urandom, $urandom};
        opsize_in     = 2'($urandom);
        inst_ptcid_in = 7'($urandom);
    endtask

    vec_t vt [9];

    initial begin
        int          nw;
        logic [31:0] fa;
        logic        held;
        checks = 0; errors = 0; m_cnt = 0; m_size = 0; m_pt = 0; last_acc = 0;
        valid_in = 0; is_mem = 0; opsize_in = 0; inst_ptcid_in = 0; wbaq_isfull = 0;
        for (int i = 0; i < 4; i++) begin res[i] = 0; addr[i] = 0; end

        vt[0] = '{4'b0000, 32'h0,   0};
        vt[1] = '{4'b0001, 32'h100, 1};
        vt[2] = '{4'b0010, 32'h200, 1};
        vt[3] = '{4'b0100, 32'h300, 1};
        vt[4] = '{4'b1000, 32'h400, 1};
        vt[5] = '{4'b0110, 32'h200, 2};
        vt[6] = '{4'b1010, 32'h200, 2};
        vt[7] = '{4'b1111, 32'h100, 4};
        vt[8] = '{4'b1100, 32'h300, 2};

        // Reset then idle
        do_reset();
        for (int c = 0; c < 10; c++) step();

        // Single memory destination in slot 2
        valid_in = 1; is_mem = 4'b0010;
        addr[1] = 32'h0000_1000; res[1] = 64'h1122_3344_5566_7788;
        opsize_in = 2'b11; inst_ptcid_in = 7'h15;
        step();
        valid_in = 0;
        nw = 0;
        for (int c = 0; c < 4; c++) begin
            #1;
            if (wb_valid) begin
                chk("single_addr", 64'(wb_memaddr), 64'h1000);
                chk("single_data", wb_memdata, 64'h1122_3344_5566_7788);
                chk("single_size", 64'(wb_size), 64'h3);
                chk("single_ptcid", 64'(wb_ptcid), 64'h15);
            end
            step();
            nw += int'(s_valid);
            chk("single_stall", 64'(s_stall), 64'h0);
        end
        chk("single_count", 64'(nw), 64'h1);

        // Four destinations with a back-to-back follow-on instruction
        set_instr(4'b1111, 32'h100, 32'h200, 32'h300, 32'h400);
        step();
        valid_in = 0;
        for (int c = 0; c < 4; c++) begin
            if (c == 3) set_instr(4'b0001, 32'h500, 32'h0, 32'h0, 32'h0);
            step();
            chk("four_valid", 64'(s_valid), 64'h1);
            chk("four_addr", 64'(s_addr), 64'(32'h100 * (c + 1)));
            chk("four_stall", 64'(s_stall), (c < 3) ? 64'h1 : 64'h0);
        end
        valid_in = 0;
        step();
        chk("b2b_valid", 64'(s_valid), 64'h1);
        chk("b2b_addr", 64'(s_addr), 64'h500);
        step();

        // Back-pressure for three cycles
        do_reset();
        set_instr(4'b0011, 32'h10, 32'h20, 32'h0, 32'h0);
        step();
        valid_in = 0;
        wbaq_isfull = 1;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("bp_hold_valid", 64'(s_valid), 64'h0);
            chk("bp_hold_addr", 64'(s_addr), 64'h10);
        end
        wbaq_isfull = 0;
        step();
        chk("bp_first", 64'(s_addr), 64'h10);
        step();
        chk("bp_second", 64'(s_addr), 64'h20);
        chk("bp_second_v", 64'(s_valid), 64'h1);
`ifdef WB_MEM_SEQ_FULLCNT_EN
        chk("bp_count", 64'(full_cycles), 64'h3);
`endif
        step();

        // No memory destinations
        set_instr(4'b0000, 32'h1, 32'h2, 32'h3, 32'h4);
        step();
        chk("nomem_stall", 64'(s_stall), 64'h0);
        valid_in = 0;
        step();
        chk("nomem_busy", 64'(s_busy), 64'h0);

        // Abort mid-sequence after the first of three writes
        set_instr(4'b0111, 32'h40, 32'h50, 32'h60, 32'h0);
        step();
        valid_in = 0;
        step();
        chk("abort_pre", 64'(s_valid), 64'h1);
        do_reset();
        for (int c = 0; c < 4; c++) begin
            step();
            chk("abort_after", 64'(s_valid), 64'h0);
        end

        // Vector table: count writes and check the first address, queue never full
        for (int v = 0; v < 9; v++) begin
            set_instr(vt[v].mem, 32'h100, 32'h200, 32'h300, 32'h400);
            step();
            valid_in = 0;
            nw = 0; fa = 32'h0;
            for (int c = 0; c < 6; c++) begin
                step();
                if (s_valid && nw == 0) fa = s_addr;
                nw += int'(s_valid);
            end
            chk($sformatf("vec%0d_count", v), 64'(nw), 64'(vt[v].nwrites));
            chk($sformatf("vec%0d_first", v), 64'(fa), 64'(vt[v].first_addr));
        end

        // Random traffic; upstream holds its instruction until accepted
        held = 1'b0;
        for (int c = 0; c < 500; c++) begin
            if (!held) begin
                set_instr(4'($urandom), {$urandom}, {$urandom}, {$urandom}, {$urandom});
                valid_in = ($urandom_range(0, 3) != 0);
            end
            wbaq_isfull = ($urandom_range(0, 3) == 0);
            step();
            held = valid_in && !last_acc;
        end
        valid_in = 0; wbaq_isfull = 0;
        for (int c = 0; c < 6; c++) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
